// File: rtl/breakout_pkg.sv
// ============================================================================
// Module : breakout_pkg
// Brief  : State encoding and default game constants for the breakout control.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package breakout_pkg;

   typedef enum logic [2:0] {
      ST_NEWGAME = 3'd0,
      ST_PLAY    = 3'd1,
      ST_NEWBALL = 3'd2,
      ST_OVER    = 3'd3,
      ST_WIN     = 3'd4
   } state_t;

   localparam int LIVES_INIT  = 3;
   localparam int NUM_BRICKS  = 48;
   localparam int WAIT_FRAMES = 120;
   localparam int TIMER_W     = 7;

   // States that freeze the playfield for a fixed number of frames.
   function automatic logic is_wait_state(input state_t s);
      return (s == ST_NEWBALL) || (s == ST_OVER) || (s == ST_WIN);
   endfunction

endpackage

`default_nettype wire

// File: rtl/score_bcd_counter.sv
// ============================================================================
// Module : score_bcd_counter
// Brief  : Four-digit BCD score register with clear and saturating increment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module score_bcd_counter
   import breakout_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        inc,
   output logic [15:0] score
);

   logic [15:0] score_q;
   logic [15:0] score_d;
   logic        carry;

   always_comb begin
      score_d = score_q;
      carry   = 1'b1;
      if (clr) begin
         score_d = '0;
      end else if (inc && (score_q != 16'h9999)) begin
         // Ripple the carry from the least significant digit upward.
         for (int i = 0; i < 4; i++) begin
            if (carry) begin
               if (score_q[4*i +: 4] == 4'd9) begin
                  score_d[4*i +: 4] = 4'd0;
               end else begin
                  score_d[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                  carry             = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         score_q <= '0;
      end else begin
         score_q <= score_d;
      end
   end

   assign score = score_q;

endmodule

`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
// ============================================================================
// Module : breakout_game_ctrl
// Brief  : Game-flow FSM tracking score, lives, bricks and inter-round waits.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module breakout_game_ctrl
   import breakout_pkg::*;
#(
   parameter int LIVES_INIT  = breakout_pkg::LIVES_INIT,
   parameter int NUM_BRICKS  = breakout_pkg::NUM_BRICKS,
   parameter int WAIT_FRAMES = breakout_pkg::WAIT_FRAMES
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        refr_tick,
   input  logic [4:0]  btn,
   input  logic        hit,
   input  logic        miss,
   output logic        gra_still,
   output logic [2:0]  state,
   output logic [15:0] score,
   output logic [1:0]  lives,
   output logic [5:0]  bricks_left
);

   localparam logic [1:0]         C_LIVES  = 2'(LIVES_INIT);
   localparam logic [5:0]         C_BRICKS = 6'(NUM_BRICKS);
   localparam logic [TIMER_W-1:0] C_WAIT   = TIMER_W'(WAIT_FRAMES);

   state_t             state_q,  state_d;
   logic               still_q;
   logic [1:0]         lives_q,  lives_d;
   logic [5:0]         bricks_q, bricks_d;
   logic [TIMER_W-1:0] timer_q,  timer_d;
   logic               score_clr, score_inc;
   logic               timer_done, pressed;

   assign timer_done = (timer_q == '0);
   assign pressed    = (btn != 5'd0);

   always_comb begin
      state_d   = state_q;
      lives_d   = lives_q;
      bricks_d  = bricks_q;
      timer_d   = timer_q;
      score_clr = 1'b0;
      score_inc = 1'b0;
      if (refr_tick && !timer_done) begin
         timer_d = timer_q - 1'b1;
      end

      case (state_q)
         ST_NEWGAME: begin
            if (pressed) begin
               state_d   = ST_PLAY;
               score_clr = 1'b1;
               lives_d   = C_LIVES;
               bricks_d  = C_BRICKS;
            end
         end
         ST_PLAY: begin
            if (hit) begin
               score_inc = 1'b1;
               if (bricks_q != 6'd0) bricks_d = bricks_q - 6'd1;
            end
            if (miss && (lives_q != 2'd0)) begin
               lives_d = lives_q - 2'd1;
            end
            // Clearing the last brick wins even if the ball was lost too.
            if (hit && (bricks_q == 6'd1)) begin
               state_d = ST_WIN;
            end else if (miss) begin
               state_d = (lives_q <= 2'd1) ? ST_OVER : ST_NEWBALL;
            end
            if (is_wait_state(state_d)) begin
               timer_d = C_WAIT;
            end
         end
         ST_NEWBALL: begin
            if (timer_done && pressed) state_d = ST_PLAY;
         end
         ST_OVER, ST_WIN: begin
            if (timer_done) state_d = ST_NEWGAME;
         end
         default: begin
            state_d = ST_NEWGAME;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_NEWGAME;
         still_q  <= 1'b1;
         lives_q  <= C_LIVES;
         bricks_q <= C_BRICKS;
         timer_q  <= '0;
      end else begin
         state_q  <= state_d;
         still_q  <= (state_d != ST_PLAY);
         lives_q  <= lives_d;
         bricks_q <= bricks_d;
         timer_q  <= timer_d;
      end
   end

   score_bcd_counter u_score (
      .clk   (clk),
      .reset (reset),
      .clr   (score_clr),
      .inc   (score_inc),
      .score (score)
   );

   assign state       = state_q;
   assign gra_still   = still_q;
   assign lives       = lives_q;
   assign bricks_left = bricks_q;

endmodule

`default_nettype wire

// File: tb/tb_breakout_game_ctrl.sv
// ============================================================================
// Module : tb_breakout_game_ctrl
// Brief  : Directed self-checking bench for breakout_game_ctrl and its scorer.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_breakout_game_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        refr_tick = 1'b0;
   logic [4:0]  btn = 5'd0;
   logic        hit = 1'b0;
   logic        miss = 1'b0;
   logic        gra_still;
   logic [2:0]  state;
   logic [15:0] score;
   logic [1:0]  lives;
   logic [5:0]  bricks_left;

   logic        sc_clr = 1'b0;
   logic        sc_inc = 1'b0;
   logic [15:0] sc_score;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   breakout_game_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .refr_tick   (refr_tick),
      .btn         (btn),
      .hit         (hit),
      .miss        (miss),
      .gra_still   (gra_still),
      .state       (state),
      .score       (score),
      .lives       (lives),
      .bricks_left (bricks_left)
   );

   score_bcd_counter u_sc (
      .clk   (clk),
      .reset (reset),
      .clr   (sc_clr),
      .inc   (sc_inc),
      .score (sc_score)
   );

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press;
      btn = 5'h01;
      cycles(1);
      btn = 5'h00;
   endtask

   task automatic hits(input int n);
      hit = 1'b1;
      cycles(n);
      hit = 1'b0;
   endtask

   task automatic lose_ball;
      miss = 1'b1;
      cycles(1);
      miss = 1'b0;
   endtask

   task automatic ticks(input int n);
      refr_tick = 1'b1;
      cycles(n);
      refr_tick = 1'b0;
   endtask

   initial begin
      // Reset state
      cycles(3);
      check("rst_state",  state,       0);
      check("rst_still",  gra_still,   1);
      check("rst_score",  score,       16'h0000);
      check("rst_lives",  lives,       3);
      check("rst_bricks", bricks_left, 48);
      reset = 1'b0;
      cycles(2);
      check("idle_state", state, 0);

      // Start a game
      press();
      check("start_state",  state,       1);
      check("start_still",  gra_still,   0);
      check("start_score",  score,       16'h0000);
      check("start_lives",  lives,       3);
      check("start_bricks", bricks_left, 48);

      hits(12);
      check("hit12_score",  score,       16'h0012);
      check("hit12_bricks", bricks_left, 36);
      lose_ball();
      check("miss1_state", state,         2);
      check("miss1_lives", lives,         2);
      check("miss1_still", gra_still,     1);
      check("miss1_timer", dut.timer_q,   120);

      // Button held throughout the NEWBALL wait
      btn = 5'h04;
      ticks(119);
      check("nb119_state", state, 2);
      ticks(1);
      check("nb120_state", state, 2);
      check("nb120_timer", dut.timer_q, 0);
      cycles(1);
      check("nb_resume",   state, 1);
      btn = 5'h00;

      // hit/miss ignored outside PLAY
      lose_ball();
      check("miss2_lives", lives, 1);
      hits(1);
      lose_ball();
      check("nb_ign_score",  score,       16'h0012);
      check("nb_ign_bricks", bricks_left, 36);
      check("nb_ign_lives",  lives,       1);
      ticks(120);
      press();
      check("resume2_state", state, 1);

      // Last ball lost
      lose_ball();
      check("over_state", state, 3);
      check("over_lives", lives, 0);
      hits(1);
      check("over_ign_score", score, 16'h0012);
      ticks(119);
      check("over119_state", state, 3);
      ticks(1);
      cycles(1);
      check("over_exit_state", state, 0);
      check("ng_held_score",   score, 16'h0012);
      cycles(3);
      check("ng_wait_state",   state, 0);
      press();
      check("ng2_state",  state,       1);
      check("ng2_score",  score,       16'h0000);
      check("ng2_lives",  lives,       3);
      check("ng2_bricks", bricks_left, 48);

      // Clear all bricks with a simultaneous miss on the final hit
      hits(47);
      check("b47_bricks", bricks_left, 1);
      check("b47_score",  score,       16'h0047);
      hit  = 1'b1;
      miss = 1'b1;
      cycles(1);
      hit  = 1'b0;
      miss = 1'b0;
      check("win_state",  state,       4);
      check("win_bricks", bricks_left, 0);
      check("win_lives",  lives,       2);
      check("win_score",  score,       16'h0048);
      ticks(120);
      cycles(1);
      check("win_exit", state, 0);

      // Async reset mid OVER-timer
      press();
      lose_ball();
      ticks(120);
      press();
      lose_ball();
      ticks(120);
      press();
      lose_ball();
      check("over2_state", state, 3);
      ticks(70);
      check("over2_timer50", dut.timer_q, 50);
      #2 reset = 1'b1;
      #1;
      check("async_state", state,       0);
      check("async_timer", dut.timer_q, 0);
      check("async_still", gra_still,   1);
      check("async_lives", lives,       3);
      @(negedge clk);
      reset = 1'b0;
      ticks(60);
      check("post_rst_state", state,       0);
      check("post_rst_timer", dut.timer_q, 0);

      // Standalone scorer: carry chain and saturation
      sc_inc = 1'b1;
      cycles(999);
      check("sc_0999", sc_score, 16'h0999);
      cycles(1);
      check("sc_1000", sc_score, 16'h1000);
      cycles(8999);
      check("sc_9999", sc_score, 16'h9999);
      cycles(1);
      check("sc_sat",  sc_score, 16'h9999);
      sc_inc = 1'b0;
      sc_clr = 1'b1;
      cycles(1);
      sc_clr = 1'b0;
      check("sc_clr",  sc_score, 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
